riscv_fetch_unit: RTL and testbench

Instruction fetch front end that produces the 32-bit instruction stream consumed by the core's decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel; responses return in order.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to the core with a valid/ready handshake.
- Supports redirect (PC reload) with flush and discard of stale in-flight responses.

---
 rtl/riscv_fetch_pkg.sv | 21 ++
 rtl/riscv_fetch_unit_fifo.sv | 58 +++++
 rtl/riscv_fetch_unit.sv | 133 +++++++++++++
 tb/tb_riscv_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   ILEN             instruction / PC width
//   NOP              word shown to the core when nothing is valid (addi x0,x0,0)
//   DEFAULT_RESET_PC default reset PC
//   fetch_state_t    RUN: issuing allowed; FLUSH: draining stale responses
//   fetch_entry_t    prefetch FIFO entry {pc, instr}
package riscv_fetch_pkg;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
  localparam logic [ILEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_fetch_unit_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, instr} entries.
//   clk, rst    clock, async active-high reset
//   push, din   write an entry (ignored when full without a same-cycle pop)
//   pop, dout   consume the head; dout is the current head
//   flush       empties the FIFO; wins over push, a same-cycle pop is implied
//   full, empty, count  occupancy status (count is 0..DEPTH)
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: instruction fetch front end.
//   clk, reset                  clock, async active-high reset
//   fetch_en                    permits new requests
//   imem_req_valid/ready/addr   word request channel (valid/addr registered)
//   imem_resp_valid/data        in-order responses, never back-pressured
//   redirect_valid/pc           one-cycle PC reload with flush
//   instr_valid/ready           consumer handshake on the FIFO head
//   instruction, instr_pc       head word and its PC (NOP / 0 when idle)
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [31:0]     imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instruction,
  output logic [31:0]     instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, resp_pc, redirect_aligned;
  logic [CW-1:0] outstanding, discard, fifo_count;
  logic [CW-1:0] out_nxt, disc_redirect, disc_nxt, count_nxt;
  logic [CW:0]   credit_sum;
  logic          req_stale;
  logic          accept, held, push, pop, issue;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  head, push_entry;

  assign accept           = imem_req_valid & imem_req_ready;
  assign held             = imem_req_valid & ~imem_req_ready;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign pop              = ~fifo_empty & instr_ready;
  // A response landing in a redirect cycle belongs to the old stream.
  assign push             = imem_resp_valid & ~redirect_valid & (discard == '0)
                            & (~fifo_full | pop);
  assign push_entry       = '{pc: resp_pc, instr: imem_resp_data};

  assign out_nxt       = outstanding + CW'(accept) - CW'(imem_resp_valid);
  // A request still waiting for ready will come back stale as well.
  assign disc_redirect = out_nxt + CW'(held);
  assign count_nxt     = redirect_valid ? '0 : fifo_count + CW'(push) - CW'(pop);

  always_comb begin
    disc_nxt = discard;
    if (redirect_valid)                          disc_nxt = disc_redirect;
    else if (imem_resp_valid && discard != '0)   disc_nxt = discard - 1'b1;
  end

  // A stale held request must not advance the redirected PC when it is accepted.
  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (redirect_valid)             fetch_pc_nxt = redirect_aligned;
    else if (accept && !req_stale)  fetch_pc_nxt = fetch_pc + 32'd4;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (redirect_valid)
      state_nxt = (disc_redirect != '0) ? FLUSH : RUN;
    else if (state == FLUSH && disc_nxt == '0)
      state_nxt = RUN;
  end

  // FSM: outputs. Credit uses post-edge occupancy so a raised request always
  // has a FIFO slot reserved for its response.
  always_comb begin
    credit_sum  = {1'b0, out_nxt} + {1'b0, count_nxt};
    issue       = fetch_en && (state == RUN) && !redirect_valid && (credit_sum < DEPTH_C);
    instr_valid = ~fifo_empty;
    instruction = instr_valid ? head.instr : NOP;
    instr_pc    = instr_valid ? head.pc    : 32'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      req_stale      <= 1'b0;
      fetch_pc       <= RESET_PC;
      resp_pc        <= RESET_PC;
      outstanding    <= '0;
      discard        <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= out_nxt;
      discard     <= disc_nxt;
      if (redirect_valid) resp_pc <= redirect_aligned;
      else if (push)      resp_pc <= resp_pc + 32'd4;
      if (held) begin
        // valid/addr hold until accepted, even across a redirect
        req_stale <= req_stale | redirect_valid;
      end else begin
        imem_req_valid <= issue;
        imem_req_addr  <= fetch_pc_nxt;
        req_stale      <= 1'b0;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: stimulus pushes expected PCs,
// a monitor pops and compares on every instruction handshake.
module tb_riscv_fetch_unit;
  import riscv_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction, instr_pc;

  int n_cmp = 0;
  int n_err = 0;

  // memory model / control
  int en_ctl, stop_at, lat, ready_limit;
  int cyc = 0;
  int acc_cnt = 0;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend [$];
  pend_t       p;
  int          due;
  logic [31:0] acc_addr [$];
  int          acc_cyc [$];
  int          resp_cyc [$];
  logic [31:0] cur_resp_addr = '0;

  logic [31:0] exp_q [$];
  int          pop_cyc [$];
  logic [31:0] e;

  assign fetch_en = (en_ctl != 0) && !((stop_at != 0) && (acc_cnt >= stop_at));

  riscv_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Memory: decides ready and emits responses at the negedge before the edge.
  initial begin
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        pend.delete(); acc_addr.delete(); acc_cyc.delete(); resp_cyc.delete();
        acc_cnt = 0; imem_resp_valid = 1'b0; imem_req_ready = 1'b0;
      end else begin
        imem_resp_valid = 1'b0;
        if (pend.size() != 0 && pend[0].due == cyc) begin
          p = pend.pop_front();
          imem_resp_valid = 1'b1;
          imem_resp_data  = mk(p.addr);
          cur_resp_addr   = p.addr;
          resp_cyc.push_back(cyc);
        end
        imem_req_ready = (acc_cnt < ready_limit);
        if (imem_req_valid && imem_req_ready) begin
          due = cyc + lat;
          if (pend.size() != 0 && pend[$].due >= due) due = pend[$].due + 1;
          pend.push_back('{imem_req_addr, due});
          acc_addr.push_back(imem_req_addr);
          acc_cyc.push_back(cyc);
          acc_cnt++;
        end
      end
    end
  end

  // Monitor: compares every consumed word against the scoreboard.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (!reset && instr_valid && instr_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got pc %h expected no word", instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e);
          chk("instruction", instruction, mk(e));
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; en_ctl = 0; stop_at = 0; lat = 1; ready_limit = 1000000;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    exp_q.delete(); pop_cyc.delete();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    reset = 1'b1;
    tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instruction", instruction, NOP);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // 1: streaming, latency 1
    do_reset();
    en_ctl = 1; instr_ready = 1'b1; stop_at = 3;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    drain("t1_drained");
    chk("t1_addr1", acc_addr[1], 32'h4);
    chk("t1_addr2", acc_addr[2], 32'h8);
    chk("t1_b2b_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    chk("t1_b2b_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
    chk("t1_latency", 32'(pop_cyc[0] - resp_cyc[0]), 32'd1);

    // 2: back-pressure fills the FIFO, one pop frees exactly one credit
    do_reset();
    en_ctl = 1;
    for (int i = 0; i < 12; i++) tick();
    chk("t2_reqs", 32'(acc_cnt), 32'd4);
    chk("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
    chk("t2_head_valid", 32'(instr_valid), 32'd1);
    exp_q.push_back(32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_one_more", 32'(acc_cnt), 32'd5);
    chk("t2_addr", acc_addr[4], 32'h10);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: redirect while a request is held
    do_reset();
    en_ctl = 1; instr_ready = 1'b1; ready_limit = 2;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    for (int i = 0; i < 20 && !(imem_req_valid && imem_req_addr == 32'h8); i++) tick();
    chk("t3_held_8", imem_req_addr, 32'h8);
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    chk("t3_flush", 32'(dut.state), 32'(FLUSH));
    chk("t3_hold_a", imem_req_addr, 32'h8);
    tick(); tick();
    chk("t3_hold_b", imem_req_addr, 32'h8);
    chk("t3_hold_v", 32'(imem_req_valid), 32'd1);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    ready_limit = 1000000; stop_at = 5;
    drain("t3_drained");
    chk("t3_next_req", acc_addr[3], 32'h100);

    // 4: two responses in flight at latency 3 are discarded
    do_reset();
    lat = 3; en_ctl = 1; instr_ready = 1'b1; stop_at = 2;
    for (int i = 0; i < 20 && acc_cnt < 2; i++) tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200; stop_at = 4;
    tick();
    redirect_valid = 1'b0;
    chk("t4_idle_valid", 32'(instr_valid), 32'd0);
    chk("t4_idle_nop", instruction, NOP);
    chk("t4_idle_pc", instr_pc, 32'h0);
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    drain("t4_drained");
    chk("t4_next_req", acc_addr[2], 32'h200);

    // 5: redirect coincident with a pop and a response
    do_reset();
    en_ctl = 1; stop_at = 3;
    for (int i = 0; i < 20 && !(imem_resp_valid && cur_resp_addr == 32'h8); i++) tick();
    chk("t5_resp8", cur_resp_addr, 32'h8);
    exp_q.push_back(32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h300; instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("t5_empty", 32'(instr_valid), 32'd0);
    exp_q.push_back(32'h300); exp_q.push_back(32'h304);
    stop_at = 5;
    drain("t5_drained");

    // 6: PC wrap, then reset mid-run
    do_reset();
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0; en_ctl = 1; stop_at = 4;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h4);
    drain("t6_drained");
    chk("t6_wrap_req", acc_addr[2], 32'h0);
    instr_ready = 1'b0; stop_at = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_busy", 32'(instr_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_req_addr", imem_req_addr, 32'h0);
    chk("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_instruction", instruction, NOP);
    chk("t6_rst_instr_pc", instr_pc, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
